// File: rtl/segbuf_rx.sv
// EVR segmented data buffer receiver: comma phase tracking, frame parse, checksum.
// Define SEGBUF_RX_DBUS_EN to register the distributed bus byte onto dbus.
module segbuf_rx #(
    parameter int SEG_BYTES = 16,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_valid,
    input  logic [15:0]            rx_data,
    input  logic [1:0]             rx_is_k,
    output logic                   seg_valid,
    output logic [7:0]             seg_addr,
    output logic [8*SEG_BYTES-1:0] seg_data,
    output logic                   chk_err,
    output logic                   proto_err,
    output logic [CNT_W-1:0]       ok_cnt,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [7:0]             dbus
);
    localparam int IW = $clog2(SEG_BYTES);
    localparam logic [IW-1:0] LAST = IW'(SEG_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, DATA, STOP, CHK_H, CHK_L
    } state_t;

    state_t                 state_q;
    logic                   phase_q;
    logic [15:0]            sum_q;
    logic [7:0]             addr_q;
    logic [7:0]             chk_hi_q;
    logic [IW-1:0]          idx_q;
    logic [8*SEG_BYTES-1:0] shadow_q;

    logic        comma, seg_w, k, sof, eof, match;
    logic        good_ev, chk_ev, prot_ev;
    logic [7:0]  b;
    logic [15:0] sum_nx;

    always_comb begin
        b      = rx_data[7:0];
        k      = rx_is_k[0];
        comma  = rx_is_k[1] && (rx_data[15:8] == 8'hBC);
        seg_w  = rx_valid && phase_q;
        sof    = k && (b == 8'h5C);
        eof    = k && (b == 8'h3C);
        sum_nx = sum_q + {8'h00, b};
        match  = ({chk_hi_q, b} == ~sum_q);
        good_ev = seg_w && (state_q == CHK_L) && !k && match;
        chk_ev  = seg_w && (state_q == CHK_L) && !k && !match;
        // STOP wants exactly K28.1; every other state wants data bytes
        prot_ev = seg_w && (state_q != IDLE) &&
                  (sof || ((state_q == STOP) ? !eof : k));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= 1'b0;
            sum_q     <= '0;
            addr_q    <= '0;
            chk_hi_q  <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            seg_valid <= 1'b0;
            chk_err   <= 1'b0;
            proto_err <= 1'b0;
            seg_addr  <= '0;
            seg_data  <= '0;
            ok_cnt    <= '0;
            err_cnt   <= '0;
        end else begin
            seg_valid <= good_ev;
            chk_err   <= chk_ev;
            proto_err <= prot_ev;
            if (good_ev) begin
                seg_addr <= addr_q;
                seg_data <= shadow_q;
            end
            if (good_ev && (ok_cnt != '1))
                ok_cnt <= ok_cnt + 1'b1;
            if ((chk_ev || prot_ev) && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;

            if (rx_valid)
                phase_q <= comma ? 1'b1 : ~phase_q;

            if (!rx_valid) begin
                state_q <= IDLE;
            end else if (phase_q) begin
                if (sof) begin
                    sum_q   <= '0;
                    state_q <= ADDR;
                end else if (prot_ev) begin
                    state_q <= IDLE;
                end else begin
                    unique case (state_q)
                        IDLE: state_q <= IDLE;
                        ADDR: begin
                            addr_q  <= b;
                            sum_q   <= sum_nx;
                            idx_q   <= '0;
                            state_q <= DATA;
                        end
                        DATA: begin
                            shadow_q[{idx_q, 3'b000} +: 8] <= b;
                            sum_q <= sum_nx;
                            idx_q <= idx_q + 1'b1;
                            if (idx_q == LAST)
                                state_q <= STOP;
                        end
                        STOP: state_q <= CHK_H;
                        CHK_H: begin
                            chk_hi_q <= b;
                            state_q  <= CHK_L;
                        end
                        CHK_L: state_q <= IDLE;
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

`ifdef SEGBUF_RX_DBUS_EN
    logic [7:0] dbus_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dbus_q <= '0;
        else if (rx_valid && !phase_q)
            dbus_q <= rx_data[7:0];
    end

    assign dbus = dbus_q;
`else
    assign dbus = 8'h00;
`endif

endmodule
